// File: rtl/track_sensor_emitter.sv
// Simulated train pass: pulses S1..S6 in turn with rising edges one segment time apart.
// Optional macro TRACK_REVERSE_DIR_EN adds a dir input (1 = traverse S6 -> S1).
module track_sensor_emitter #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned SEG_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [SEG_W-1:0] seg_time,
`ifdef TRACK_REVERSE_DIR_EN
    input  logic             dir,
`endif
    output logic             S1,
    output logic             S2,
    output logic             S3,
    output logic             S4,
    output logic             S5,
    output logic             S6,
    output logic [2:0]       sensor_idx,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap, StDone} state_e;

    // Shortest legal segment leaves one low cycle between sensor pulses.
    localparam logic [SEG_W-1:0] SegMin    = SEG_W'(PULSE_CYCLES + 1);
    localparam logic [SEG_W-1:0] PulseLast = SEG_W'(PULSE_CYCLES - 1);
    localparam logic [SEG_W-1:0] One       = SEG_W'(1);

    state_e           state_q, state_d;
    logic [SEG_W-1:0] cnt_q, cnt_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [2:0]       step_q, step_d;
    logic             rev_q, rev_d;
    logic [5:0]       s_q, s_d;
    logic [2:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       cur_idx;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        seg_d   = seg_q;
        rev_d   = rev_q;
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
            cnt_d   = '0;
            step_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !abort) begin
                        state_d = StPulse;
                        cnt_d   = '0;
                        step_d  = '0;
                        seg_d   = (seg_time < SegMin) ? SegMin : seg_time;
`ifdef TRACK_REVERSE_DIR_EN
                        rev_d   = dir;
`endif
                    end
                end
                StPulse: begin
                    // Counter runs on through the gap; it never exceeds seg_q - 1.
                    if (cnt_q == PulseLast) begin
                        state_d = (step_q == 3'd5) ? StDone : StGap;
                    end
                    cnt_d = cnt_q + One;
                end
                StGap: begin
                    if (cnt_q == seg_q - One) begin
                        state_d = StPulse;
                        cnt_d   = '0;
                        step_d  = step_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + One;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    step_d  = '0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are decoded from the next state so they appear registered.
    always_comb begin
        cur_idx = rev_d ? (3'd6 - step_d) : (step_d + 3'd1);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
        idx_d   = busy_d ? cur_idx : 3'd0;
        s_d     = '0;
        for (int k = 0; k < 6; k++) begin
            s_d[k] = (state_d == StPulse) && (cur_idx == 3'(k + 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            seg_q   <= '0;
            step_q  <= '0;
            rev_q   <= 1'b0;
            s_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            step_q  <= step_d;
            rev_q   <= rev_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign {S6, S5, S4, S3, S2, S1} = s_q;
    assign sensor_idx = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_track_sensor_emitter.sv
// Bench for track_sensor_emitter: timeline model of a pass checked every cycle,
// plus literal checks at hand-computed cycles.
module tb_track_sensor_emitter;

    localparam int PULSE = 4;

    logic        clk = 1'b0;
    logic        rst, start, abort, dir;
    logic [15:0] seg_time;
    logic        S1, S2, S3, S4, S5, S6;
    logic [2:0]  sensor_idx;
    logic        busy, done;
    logic [5:0]  s_vec;

    assign s_vec = {S6, S5, S4, S3, S2, S1};

    track_sensor_emitter #(
        .PULSE_CYCLES (PULSE),
        .SEG_W        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .seg_time   (seg_time),
`ifdef TRACK_REVERSE_DIR_EN
        .dir        (dir),
`endif
        .S1         (S1),
        .S2         (S2),
        .S3         (S3),
        .S4         (S4),
        .S5         (S5),
        .S6         (S6),
        .sensor_idx (sensor_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic chk_en = 1'b0;

    // Pass model: a pass started at the end of cycle t0 puts sensor k's pulse at
    // cycles t0 + 1 + k*seg .. +PULSE-1, and done at t0 + 5*seg + PULSE + 1.
    logic       m_active = 1'b0;
    logic       m_rev = 1'b0;
    int         m_t0 = 0;
    int         m_seg = PULSE + 1;
    logic [5:0] exp_s = '0;
    logic       exp_busy = 1'b0;
    logic       exp_done = 1'b0;
    int         exp_idx = 0;
    logic       idx_chk = 1'b1;

    always @(posedge clk) begin
        int   e, endc, k, off, num;
        logic was_busy;
        endc     = 5 * m_seg + PULSE + 1;
        e        = cyc - m_t0;
        was_busy = m_active && e >= 1 && e <= endc;
        if (rst) begin
            m_active = 1'b0;
        end else if (was_busy) begin
            if (abort) m_active = 1'b0;
        end else if (start && !abort) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_seg    = (int'(seg_time) < PULSE + 1) ? PULSE + 1 : int'(seg_time);
`ifdef TRACK_REVERSE_DIR_EN
            m_rev    = dir;
`else
            m_rev    = 1'b0;
`endif
        end
        cyc      = cyc + 1;
        endc     = 5 * m_seg + PULSE + 1;
        e        = cyc - m_t0;
        exp_s    = '0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_idx  = 0;
        idx_chk  = 1'b1;
        if (m_active && e >= 1 && e <= endc) begin
            exp_busy = 1'b1;
            exp_done = (e == endc);
            k        = (e - 1) / m_seg;
            off      = (e - 1) % m_seg;
            if (off < PULSE) begin
                num            = m_rev ? 6 - k : k + 1;
                exp_s[num - 1] = 1'b1;
                exp_idx        = num;
            end else begin
                idx_chk = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if (s_vec !== exp_s || busy !== exp_busy || done !== exp_done ||
                (idx_chk && int'(sensor_idx) != exp_idx)) begin
                fails++;
                $display("FAIL model cycle %0d: S=%b exp %b busy=%b exp %b done=%b exp %b idx=%0d exp %0d",
                         cyc, s_vec, exp_s, busy, exp_busy, done, exp_done, sensor_idx, exp_idx);
            end
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Lands on the negedge of cycle c (c must not be in the past).
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    initial begin
        int s0, d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; dir = 1'b0; seg_time = '0;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        chk("reset_s", int'(s_vec), 0);
        chk("reset_busy_done", int'({busy, done, sensor_idx}), 0);

        // Normal pass, start on the first cycle out of reset; start/seg_time poked mid-pass.
        rst = 1'b0; start = 1'b1; seg_time = 16'd10; s0 = cyc; d0 = done_cnt;
        tick(1);
        start = 1'b0;
        wait_to(s0 + 1);  chk("norm_s1_rise", int'(s_vec), 6'b000001);
        chk("norm_idx1", int'(sensor_idx), 1);
        wait_to(s0 + 4);  chk("norm_s1_last", int'(s_vec), 6'b000001);
        wait_to(s0 + 5);  chk("norm_gap", int'({busy, s_vec}), 7'b1000000);
        wait_to(s0 + 11); chk("norm_s2_rise", int'(s_vec), 6'b000010);
        chk("norm_idx2", int'(sensor_idx), 2);
        start = 1'b1; seg_time = 16'd3;
        tick(1);
        start = 1'b0;
        wait_to(s0 + 21); chk("norm_s3_rise", int'(s_vec), 6'b000100);
        wait_to(s0 + 51); chk("norm_s6_rise", int'(s_vec), 6'b100000);
        chk("norm_idx6", int'(sensor_idx), 6);
        wait_to(s0 + 54); chk("norm_s6_last", int'(s_vec), 6'b100000);
        wait_to(s0 + 55); chk("norm_done", int'({busy, done, s_vec}), 8'b11000000);
        wait_to(s0 + 56); chk("norm_idle", int'({busy, done}), 0);
        tick(2);
        chk("norm_single_done", done_cnt - d0, 1);

        // Clamp: seg_time 2 becomes 5.
        seg_time = 16'd2; start = 1'b1; s0 = cyc;
        tick(1);
        start = 1'b0;
        wait_to(s0 + 1);  chk("clamp_s1", int'(s_vec), 6'b000001);
        wait_to(s0 + 5);  chk("clamp_low", int'({busy, s_vec}), 7'b1000000);
        wait_to(s0 + 6);  chk("clamp_s2", int'(s_vec), 6'b000010);
        wait_to(s0 + 11); chk("clamp_s3", int'(s_vec), 6'b000100);
        wait_to(s0 + 30); chk("clamp_done", int'(done), 1);
        tick(3);

        // Abort during the S3 pulse.
        seg_time = 16'd10; start = 1'b1; s0 = cyc; d0 = done_cnt;
        tick(1);
        start = 1'b0;
        wait_to(s0 + 22); chk("abort_s3_before", int'(s_vec), 6'b000100);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_to(s0 + 23); chk("abort_after", int'({busy, s_vec, sensor_idx}), 0);
        tick(40);
        chk("abort_no_done", done_cnt - d0, 0);

        // start and abort together in IDLE.
        start = 1'b1; abort = 1'b1; s0 = cyc;
        tick(1);
        start = 1'b0; abort = 1'b0;
        wait_to(s0 + 1);  chk("start_abort_idle", int'({busy, s_vec}), 0);
        tick(3);

        // Reset mid-pass for three cycles.
        seg_time = 16'd7; start = 1'b1; s0 = cyc; d0 = done_cnt;
        tick(1);
        start = 1'b0;
        wait_to(s0 + 10); chk("rst_mid_s2", int'(s_vec), 6'b000010);
        rst = 1'b1;
        tick(1);
        wait_to(s0 + 11); chk("rst_mid_clear", int'({busy, done, s_vec, sensor_idx}), 0);
        tick(2);
        rst = 1'b0;
        tick(60);
        chk("rst_mid_no_done", done_cnt - d0, 0);

        // All-ones segment time: long gap, then abort.
        seg_time = 16'hFFFF; start = 1'b1; s0 = cyc;
        tick(1);
        start = 1'b0;
        wait_to(s0 + 4);  chk("big_s1", int'(s_vec), 6'b000001);
        wait_to(s0 + 300); chk("big_gap", int'({busy, s_vec}), 7'b1000000);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(3);

`ifdef TRACK_REVERSE_DIR_EN
        // Reverse traversal.
        seg_time = 16'd8; dir = 1'b1; start = 1'b1; s0 = cyc;
        tick(1);
        start = 1'b0; dir = 1'b0;
        wait_to(s0 + 1);  chk("rev_s6", int'(s_vec), 6'b100000);
        chk("rev_idx6", int'(sensor_idx), 6);
        wait_to(s0 + 9);  chk("rev_idx5", int'(sensor_idx), 5);
        wait_to(s0 + 41); chk("rev_s1", int'(s_vec), 6'b000001);
        chk("rev_idx1", int'(sensor_idx), 1);
        wait_to(s0 + 45); chk("rev_done", int'(done), 1);
        tick(3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
